set_job_dispatcher: RTL and testbench

//  Upstream front end for the SET candidate-counting engine. Buffers jobs (central/radius/mode + tag)
//  in a small FIFO and issues each one to the engine with a one-cycle en pulse while engine busy is low.

---
 rtl/set_job_dispatcher_if.sv | 51 +++++
 rtl/set_job_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_set_job_dispatcher.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/set_job_dispatcher_if.sv
// Job, engine and result channels of the SET job dispatcher.
// master = dispatcher side, slave = the environment (job source, engine, result sink).
interface set_job_dispatcher_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             job_valid;
    logic             job_ready;
    logic [23:0]      job_central;
    logic [11:0]      job_radius;
    logic [1:0]       job_mode;
    logic [TAG_W-1:0] job_tag;

    logic             set_busy;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_valid;
    logic [7:0]       set_candidate;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    logic [CNT_W-1:0] fifo_count;

    modport master (
        input  job_valid, job_central, job_radius, job_mode, job_tag,
        input  set_busy, set_valid, set_candidate,
        input  res_ready,
        output job_ready,
        output set_en, set_central, set_radius, set_mode,
        output res_valid, res_candidate, res_tag, res_err,
        output fifo_count
    );

    modport slave (
        output job_valid, job_central, job_radius, job_mode, job_tag,
        output set_busy, set_valid, set_candidate,
        output res_ready,
        input  job_ready,
        input  set_en, set_central, set_radius, set_mode,
        input  res_valid, res_candidate, res_tag, res_err,
        input  fifo_count
    );
endinterface

// File: rtl/set_job_dispatcher.sv
// Job FIFO + single-outstanding issue FSM in front of the SET candidate-counting engine.
// Optional WAIT timeout abort is enabled by defining SET_TIMEOUT_EN.
module set_job_dispatcher #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 511
) (
    input  logic                 clk,
    input  logic                 rst,
    set_job_dispatcher_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e state_q, state_d;

    logic [23:0]      mem_central [DEPTH];
    logic [11:0]      mem_radius  [DEPTH];
    logic [1:0]       mem_mode    [DEPTH];
    logic [TAG_W-1:0] mem_tag     [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, pop;

    logic [23:0]      hold_central_q;
    logic [11:0]      hold_radius_q;
    logic [1:0]       hold_mode_q;
    logic [TAG_W-1:0] hold_tag_q;

    logic [7:0]       res_cand_q, res_cand_d;
    logic             res_err_q, res_err_d;
    logic             res_load;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.job_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_central[wr_ptr_q] <= bus.job_central;
            mem_radius[wr_ptr_q]  <= bus.job_radius;
            mem_mode[wr_ptr_q]    <= bus.job_mode;
            mem_tag[wr_ptr_q]     <= bus.job_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef SET_TIMEOUT_EN
    logic [8:0] wait_cnt_q;
    logic       wait_expired;

    // Counter reads 0 in the first WAIT cycle, so expiry at TIMEOUT-1 gives TIMEOUT WAIT cycles.
    assign wait_expired = (wait_cnt_q == 9'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == StIssue) begin
            wait_cnt_q <= '0;
        end else if (state_q == StWait) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        res_load   = 1'b0;
        res_cand_d = '0;
        res_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !bus.set_busy) begin
                    pop = 1'b1;
                    if (mem_mode[rd_ptr_q] == 2'd3) begin
                        // Illegal mode is answered locally; the engine never sees it.
                        res_load  = 1'b1;
                        res_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.set_valid) begin
                    res_load   = 1'b1;
                    res_cand_d = bus.set_candidate;
                    state_d    = StResp;
                end
`ifdef SET_TIMEOUT_EN
                else if (wait_expired) begin
                    res_load  = 1'b1;
                    res_err_d = 1'b1;
                    state_d   = StResp;
                end
`endif
            end
            StResp: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            hold_central_q <= '0;
            hold_radius_q  <= '0;
            hold_mode_q    <= '0;
            hold_tag_q     <= '0;
            res_cand_q     <= '0;
            res_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                hold_central_q <= mem_central[rd_ptr_q];
                hold_radius_q  <= mem_radius[rd_ptr_q];
                hold_mode_q    <= mem_mode[rd_ptr_q];
                hold_tag_q     <= mem_tag[rd_ptr_q];
            end
            if (res_load) begin
                res_cand_q <= res_cand_d;
                res_err_q  <= res_err_d;
            end
        end
    end

    assign bus.job_ready     = !full;
    assign bus.fifo_count    = count_q;
    assign bus.set_en        = (state_q == StIssue);
    assign bus.set_central   = hold_central_q;
    assign bus.set_radius    = hold_radius_q;
    assign bus.set_mode      = hold_mode_q;
    assign bus.res_valid     = (state_q == StResp);
    assign bus.res_candidate = res_cand_q;
    assign bus.res_tag       = hold_tag_q;
    assign bus.res_err       = res_err_q;

`ifndef SYNTHESIS
    en_no_repeat: assert property (@(posedge clk) disable iff (rst) bus.set_en |=> !bus.set_en);
    count_bound:  assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Scoreboard bench for set_job_dispatcher with a behavioural SET engine downstream.
module tb_set_job_dispatcher;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [7:0]       cand;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    set_job_dispatcher_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    set_job_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(511)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lattice points of the 16x16 grid inside circle A / B, combined per mode.
    function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                             input logic [1:0] m);
        int xa = int'(c[23:20]);
        int ya = int'(c[19:16]);
        int xb = int'(c[15:12]);
        int yb = int'(c[11:8]);
        int ra = int'(r[11:8]);
        int rb = int'(r[7:4]);
        int n  = 0;
        bit in_a, in_b, hit;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                in_a = ((x - xa) * (x - xa) + (y - ya) * (y - ya)) <= ra * ra;
                in_b = ((x - xb) * (x - xb) + (y - yb) * (y - yb)) <= rb * rb;
                case (m)
                    2'd0:    hit = in_a;
                    2'd1:    hit = in_a && in_b;
                    2'd2:    hit = in_a ^ in_b;
                    default: hit = 1'b0;
                endcase
                if (hit) n++;
            end
        end
        return n[7:0];
    endfunction

    // Engine model: accepts en while idle, stays busy for a latency, then pulses valid.
    logic       eng_busy;
    logic       hold_busy;
    logic       eng_mute;
    int         eng_lat_fix;
    int         eng_left;
    logic [7:0] eng_res;

    assign bus.set_busy = eng_busy | hold_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy          <= 1'b0;
            eng_left          <= 0;
            eng_res           <= '0;
            bus.set_valid     <= 1'b0;
            bus.set_candidate <= '0;
        end else begin
            bus.set_valid <= 1'b0;
            if (bus.set_en && !eng_busy) begin
                eng_busy <= 1'b1;
                eng_left <= (eng_lat_fix != 0) ? eng_lat_fix : int'($urandom_range(2, 8));
                eng_res  <= set_count(bus.set_central, bus.set_radius, bus.set_mode);
            end else if (eng_busy) begin
                if (eng_left <= 1) begin
                    eng_busy <= 1'b0;
                    if (!eng_mute) begin
                        bus.set_valid     <= 1'b1;
                        bus.set_candidate <= eng_res;
                    end
                end else begin
                    eng_left <= eng_left - 1;
                end
            end
        end
    end

    int               en_count  = 0;
    int               res_seen  = 0;
    logic             en_prev   = 1'b0;
    logic [7:0]       last_cand = '0;
    logic [TAG_W-1:0] last_tag  = '0;
    logic             last_err  = 1'b0;

    always @(negedge clk) begin
        if (!rst && bus.set_en) begin
            en_count <= en_count + 1;
            check("en_single", {31'b0, en_prev}, 32'd0);
        end
        en_prev <= bus.set_en;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.res_valid && bus.res_ready) begin
            res_seen  <= res_seen + 1;
            last_cand <= bus.res_candidate;
            last_tag  <= bus.res_tag;
            last_err  <= bus.res_err;
            check("sb_pending", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("res_cand", {24'b0, bus.res_candidate}, {24'b0, e.cand});
                check("res_tag", 32'(bus.res_tag), 32'(e.tag));
                check("res_err", {31'b0, bus.res_err}, {31'b0, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                            input logic [TAG_W-1:0] t, input bit to_err, output bit acc);
        exp_t e;
        bus.job_valid   = 1'b1;
        bus.job_central = c;
        bus.job_radius  = r;
        bus.job_mode    = m;
        bus.job_tag     = t;
        acc             = bus.job_ready;
        e.tag           = t;
        e.err           = (m == 2'd3) || to_err;
        e.cand          = e.err ? 8'd0 : set_count(c, r, m);
        if (acc) sb.push_back(e);
        step();
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            step();
            i++;
        end
        step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        bit acc;
        int e0, e1, r0, n;
        exp_t hd;
        logic [23:0] c;
        logic [11:0] r;

        rst             = 1'b1;
        hold_busy       = 1'b0;
        eng_mute        = 1'b0;
        eng_lat_fix     = 0;
        bus.job_valid   = 1'b0;
        bus.job_central = '0;
        bus.job_radius  = '0;
        bus.job_mode    = '0;
        bus.job_tag     = '0;
        bus.res_ready   = 1'b1;
        repeat (2) step();
        check("rst_job_ready", {31'b0, bus.job_ready}, 32'd1);
        check("rst_set_en", {31'b0, bus.set_en}, 32'd0);
        check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_res_cand", {24'b0, bus.res_candidate}, 32'd0);
        check("rst_set_central", {8'b0, bus.set_central}, 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // Single job: two-stage issue latency, Gauss circle r=3 gives 29 points.
        e0 = en_count;
        push_job(24'h440000, 12'h300, 2'd0, 4'd1, 1'b0, acc);
        check("t1_acc", {31'b0, acc}, 32'd1);
        check("t1_lat_early", {31'b0, bus.set_en}, 32'd0);
        step();
        check("t1_lat_en", {31'b0, bus.set_en}, 32'd1);
        wait_drain(100);
        check("t1_cand29", {24'b0, last_cand}, 32'd29);
        check("t1_tag", 32'(last_tag), 32'd1);
        check("t1_en_once", en_count - e0, 1);

        // Engine held busy: four jobs fill the FIFO, the fifth is refused.
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c = {4'(i + 3), 4'(i + 5), 4'd8, 4'd8, 8'h00};
            r = {4'(i + 1), 4'd3, 4'h0};
            push_job(c, r, 2'(i % 3), 4'(i + 2), 1'b0, acc);
            check("t2_acc", {31'b0, acc}, {31'b0, i < 4});
        end
        check("t2_count", 32'(bus.fifo_count), 32'd4);
        check("t2_ready", {31'b0, bus.job_ready}, 32'd0);
        hold_busy = 1'b0;
        wait_drain(300);

        // Illegal mode answered without touching the engine.
        e0 = en_count;
        push_job(24'h123400, 12'h210, 2'd3, 4'd7, 1'b0, acc);
        wait_drain(50);
        check("t3_no_en", en_count - e0, 0);
        check("t3_err", {31'b0, last_err}, 32'd1);
        check("t3_tag", 32'(last_tag), 32'd7);

        // Result held: outputs stable, second job blocked until the handshake.
        bus.res_ready = 1'b0;
        e0 = en_count;
        push_job(24'h77a500, 12'h420, 2'd1, 4'd9, 1'b0, acc);
        push_job(24'h3c0000, 12'h200, 2'd0, 4'd10, 1'b0, acc);
        n = 0;
        while (!bus.res_valid && n < 50) begin
            step();
            n++;
        end
        check("t4_valid", {31'b0, bus.res_valid}, 32'd1);
        hd = sb[0];
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4_stable", {19'b0, bus.res_valid, bus.res_candidate, 4'(bus.res_tag),
                                bus.res_err}, {19'b0, 1'b1, hd.cand, 4'(hd.tag), hd.err});
        end
        check("t4_en_held", en_count - e0, 1);
        bus.res_ready = 1'b1;
        wait_drain(100);
        check("t4_en_next", en_count - e0, 2);

        // Reset while the engine is working: everything discarded.
        eng_lat_fix = 40;
        push_job(24'h660000, 12'h200, 2'd0, 4'd1, 1'b0, acc);
        n = 0;
        while (!bus.set_en && n < 20) begin
            step();
            n++;
        end
        repeat (3) step();
        push_job(24'h550000, 12'h100, 2'd0, 4'd2, 1'b0, acc);
        push_job(24'h990000, 12'h100, 2'd0, 4'd3, 1'b0, acc);
        check("t5_pre_count", 32'(bus.fifo_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("t5_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("t5_set_en", {31'b0, bus.set_en}, 32'd0);
        check("t5_count", 32'(bus.fifo_count), 32'd0);
        check("t5_central", {8'b0, bus.set_central}, 32'd0);
        check("t5_ready", {31'b0, bus.job_ready}, 32'd1);
        sb.delete();
        step();
        rst = 1'b0;
        r0 = res_seen;
        e1 = en_count;
        repeat (60) step();
        check("t5_no_res", res_seen - r0, 0);
        check("t5_no_en", en_count - e1, 0);
        eng_lat_fix = 0;

        // Random mix including illegal modes; refused pushes are simply not expected.
        for (int i = 0; i < 12; i++) begin
            c = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'h00};
            r = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 4'h0};
            push_job(c, r, 2'($urandom_range(0, 3)), 4'(i), 1'b0, acc);
        end
        wait_drain(400);

`ifdef SET_TIMEOUT_EN
        // Engine answers only after the timeout; the late strobe must be ignored.
        eng_lat_fix = 600;
        push_job(24'h440000, 12'h300, 2'd0, 4'd5, 1'b1, acc);
        n = 0;
        while (!bus.set_en && n < 20) begin
            step();
            n++;
        end
        check("t6_en", {31'b0, bus.set_en}, 32'd1);
        n = 0;
        while (!bus.res_valid && n < 2000) begin
            step();
            n++;
        end
        check("t6_wait_cycles", n, 512);
        wait_drain(20);
        r0 = res_seen;
        repeat (150) step();
        check("t6_late_ignored", res_seen - r0, 0);
        check("t6_state_idle", {31'b0, bus.res_valid}, 32'd0);
        eng_lat_fix = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
